wired_fetch_queue: RTL and testbench
====================================

Name: wired_fetch_queue

Overview:
Instruction fetch queue directly downstream of the icache response port. Accepts fetch packets of up to two 32-bit instructions with a validity mask and exception flags. Stores them as individual per-instruction entries in a circular buffer and presents up to two in-order instructions per cycle to decode. Decouples icache stalls from decode back-pressure and absorbs flushes.

Parameters:
DEPTH, 8, number of per-instruction entries; power of two, >= 4
PACKED_SIZE, 32, width of the opaque per-packet payload carried with each instruction

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
flush_i  input  1  discard all stored entries and any same-cycle input
f_valid_i  input  1  fetch packet valid
f_ready_o  input-side output  1  queue can accept a packet
f_mask_i  input  2  bit0 = word at pc[31:3]|0x0 valid; bit1 = word at pc[31:3]|0x4 valid
f_pc_i  input  32  fetch pc of packet
f_inst_i  input  2x32  instruction words; slot0 = lower address
f_pkg_i  input  PACKED_SIZE  payload, copied into every entry of the packet
f_excp_i  input  4  {ppi, pif, tlbr, adef}, copied into every entry of the packet
d_valid_o  output  2  output slot valid; d_valid_o[1] implies d_valid_o[0]
d_ready_i  input  1  decode consumes all valid output slots this cycle
d_pc_o  output  2x32  per-slot instruction pc
d_inst_o  output  2x32  per-slot instruction
d_pkg_o  output  2xPACKED_SIZE  per-slot payload
d_excp_o  output  2x4  per-slot exception flags
count_o  output  log2(DEPTH)+1  current occupancy (debug/perf)

Behaviour:
- Storage: DEPTH entries of {pc, inst, pkg, excp}; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; occupancy count held separately, 0..DEPTH.
- Push: when f_valid_i && f_ready_o && !flush_i. Entries are written compacted in order:
  - slot0 word if mask[0], with pc = {pc[31:3],3'b000};
  - then slot1 word if mask[1], with pc = {pc[31:3],3'b100}.
  - push_n = popcount(mask), 0..2; mask 2'b00 is accepted and writes nothing.
- f_ready_o = (DEPTH - count) >= 2. Combinational from registered count only; never depends on f_valid_i or d_ready_i.
- Output slots:
  - d_valid_o[0] = count >= 1; d_valid_o[1] = count >= 2.
  - Slot0 is the entry at head; slot1 is at head+1 (wrapped).
  - Data fields are don't-care when the slot is not valid.
- Pop: when d_ready_i, pop_n = popcount(d_valid_o); head advances by pop_n.
- Count update: count_next = count + push_n - pop_n. Simultaneous push and pop are allowed in any combination. Full (count = DEPTH) and empty (count = 0) are distinguished by count, not by pointers.
- Flush_i:
  - Next cycle: count = 0 and head = tail = 0.
  - Same-cycle push and pop are ignored; d_valid_o = 0 from the next cycle.
- Reset: count = 0, head = tail = 0, d_valid_o = 0, f_ready_o = 1 from the first cycle after reset; storage contents are not reset. Reset mid-operation behaves as flush.
- Latency without bypass: a packet pushed in cycle N is visible on d_* in cycle N+1.
- Ordering: strict program order; entries never reordered or duplicated.

Optional Feature:
WIRED_FQ_BYPASS_EN
- Defined: when count == 0 and an accepted push occurs with no flush, the compacted incoming instructions are driven on d_* in the same cycle (d_valid_o = push count pattern).
  - If d_ready_i is high, they are consumed and not written.
  - Otherwise they are written as normal.
- Undefined: no bypass; minimum latency 1 cycle as above.

Test Plan:
- Reset, then push pc=0x1C000000, mask=11, inst={0x02800421 (slot1), 0x00100000 (slot0)}, d_ready_i=0 -> next cycle d_valid_o=11, d_pc_o[0]=0x1C000000, d_pc_o[1]=0x1C000004, count_o=2.
- Push pc=0x1C000004, mask=10 -> single entry, d_pc_o[0]=0x1C000004, d_valid_o=01.
- Fill with d_ready_i=0 until count_o=7 (DEPTH=8) -> f_ready_o=0; a held f_valid_i is not accepted. Pop 2 -> f_ready_o=1 the same cycle count drops to 5.
- Steady state with mask=11 push and d_ready_i=1 every cycle across pointer wrap (20 packets) -> all 40 pcs emerge in order; count_o stays constant.
- Push with f_excp_i.tlbr=1, mask=01 -> one entry with d_excp_o[0]=0010. Then flush_i with count=4 and a concurrent push -> next cycle d_valid_o=00, count_o=0.
- With WIRED_FQ_BYPASS_EN, empty queue, push mask=11, d_ready_i=1 -> d_valid_o=11 in the same cycle; count_o remains 0 the next cycle.

Source files
------------

// File: rtl/wired_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for wired_fetch_queue.
// master = fetch/decode environment, slave = the queue itself.
interface wired_fetch_queue_if #(
  parameter int PACKED_SIZE = 32
) ();
  logic                        f_valid;
  logic                        f_ready;
  logic [1:0]                  f_mask;
  logic [31:0]                 f_pc;
  logic [1:0][31:0]            f_inst;
  logic [PACKED_SIZE-1:0]      f_pkg;
  logic [3:0]                  f_excp;
  logic [1:0]                  d_valid;
  logic                        d_ready;
  logic [1:0][31:0]            d_pc;
  logic [1:0][31:0]            d_inst;
  logic [1:0][PACKED_SIZE-1:0] d_pkg;
  logic [1:0][3:0]             d_excp;

  modport master (
    output f_valid, f_mask, f_pc, f_inst, f_pkg, f_excp, d_ready,
    input  f_ready, d_valid, d_pc, d_inst, d_pkg, d_excp
  );

  modport slave (
    input  f_valid, f_mask, f_pc, f_inst, f_pkg, f_excp, d_ready,
    output f_ready, d_valid, d_pc, d_inst, d_pkg, d_excp
  );
endinterface

// File: rtl/wired_fetch_queue.sv
// Instruction fetch queue: compacts 2-word fetch packets into a circular buffer, issues up to 2 in order.
// Optional same-cycle empty-queue bypass enabled by defining WIRED_FQ_BYPASS_EN.
module wired_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int PACKED_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  wired_fetch_queue_if.slave      fq_io,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            inst;
    logic [PACKED_SIZE-1:0] pkg;
    logic [3:0]             excp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t [1:0]    in_s;
  entry_t [1:0]    out_s;
  logic [1:0]      valid_s;
  logic [1:0]      push_n_s, pop_n_s, wr_n_s, adv_n_s;
  logic            ready_s, accept_s, bypass_s;

  assign ready_s        = (CW'(DEPTH) - count_q) >= CW'(2);
  assign fq_io.f_ready  = ready_s;
  assign accept_s       = fq_io.f_valid && ready_s && !flush_i;
  assign count_o        = count_q;

`ifdef WIRED_FQ_BYPASS_EN
  assign bypass_s = accept_s && (count_q == CW'(0));
`else
  assign bypass_s = 1'b0;
`endif

  // Compact the packet: the first valid word always lands in slot 0.
  always_comb begin
    in_s[1].pc   = {fq_io.f_pc[31:3], 3'b100};
    in_s[1].inst = fq_io.f_inst[1];
    in_s[1].pkg  = fq_io.f_pkg;
    in_s[1].excp = fq_io.f_excp;
    if (fq_io.f_mask[0]) begin
      in_s[0].pc   = {fq_io.f_pc[31:3], 3'b000};
      in_s[0].inst = fq_io.f_inst[0];
      in_s[0].pkg  = fq_io.f_pkg;
      in_s[0].excp = fq_io.f_excp;
    end else begin
      in_s[0] = in_s[1];
    end
    push_n_s = {1'b0, fq_io.f_mask[0]} + {1'b0, fq_io.f_mask[1]};
  end

  // Output slot selection, pop accounting and next-state pointers.
  always_comb begin
    valid_s = 2'b00;
    out_s   = '0;
    if (bypass_s) begin
      out_s = in_s;
      case (push_n_s)
        2'd2:    valid_s = 2'b11;
        2'd1:    valid_s = 2'b01;
        default: valid_s = 2'b00;
      endcase
    end else begin
      out_s[0] = mem_q[head_q];
      out_s[1] = mem_q[head_q + PW'(1)];
      valid_s  = {count_q >= CW'(2), count_q >= CW'(1)};
    end

    if (fq_io.d_ready) begin
      pop_n_s = {1'b0, valid_s[0]} + {1'b0, valid_s[1]};
    end else begin
      pop_n_s = 2'd0;
    end

    // A consumed bypass never touches storage.
    if (bypass_s && fq_io.d_ready) begin
      wr_n_s  = 2'd0;
      adv_n_s = 2'd0;
    end else if (accept_s) begin
      wr_n_s  = push_n_s;
      adv_n_s = pop_n_s;
    end else begin
      wr_n_s  = 2'd0;
      adv_n_s = pop_n_s;
    end

    count_d = count_q + CW'(wr_n_s) - CW'(adv_n_s);
    head_d  = head_q + PW'(adv_n_s);
    tail_d  = tail_q + PW'(wr_n_s);
  end

  assign fq_io.d_valid   = valid_s;
  assign fq_io.d_pc[0]   = out_s[0].pc;
  assign fq_io.d_pc[1]   = out_s[1].pc;
  assign fq_io.d_inst[0] = out_s[0].inst;
  assign fq_io.d_inst[1] = out_s[1].inst;
  assign fq_io.d_pkg[0]  = out_s[0].pkg;
  assign fq_io.d_pkg[1]  = out_s[1].pkg;
  assign fq_io.d_excp[0] = out_s[0].excp;
  assign fq_io.d_excp[1] = out_s[1].excp;

  // Pointer and occupancy registers; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      if (wr_n_s != 2'd0) begin
        mem_q[tail_q] <= in_s[0];
      end
      if (wr_n_s == 2'd2) begin
        mem_q[tail_q + PW'(1)] <= in_s[1];
      end
    end
  end
endmodule

// File: tb/tb_wired_fetch_queue.sv
// Directed self-checking bench for wired_fetch_queue (DEPTH=8).
module tb_wired_fetch_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_i;
  logic [3:0] count_o;
  int         errors = 0;
  int         checks = 0;

  wired_fetch_queue_if #(.PACKED_SIZE(32)) fq_if ();

  wired_fetch_queue #(.DEPTH(8), .PACKED_SIZE(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .fq_io   (fq_if),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [3:0] ex);
    fq_if.f_valid   = v;
    fq_if.f_mask    = m;
    fq_if.f_pc      = pc;
    fq_if.f_inst[0] = i0;
    fq_if.f_inst[1] = i1;
    fq_if.f_excp    = ex;
    fq_if.f_pkg     = pc ^ 32'hC0DE_0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; fq_if.d_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (fq_if.d_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", fq_if.d_valid); end
    checks++; if (fq_if.f_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", fq_if.f_ready); end
  endtask

  task automatic test_basic();
    drive(1'b1, 2'b11, 32'h1C00_0000, 32'h0010_0000, 32'h0280_0421, 4'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++; if (fq_if.d_valid !== 2'b11) begin errors++; $display("FAIL basic_valid: got %b expected 11", fq_if.d_valid); end
    checks++; if (fq_if.d_pc[0] !== 32'h1C00_0000) begin errors++; $display("FAIL basic_pc0: got %h expected 1c000000", fq_if.d_pc[0]); end
    checks++; if (fq_if.d_pc[1] !== 32'h1C00_0004) begin errors++; $display("FAIL basic_pc1: got %h expected 1c000004", fq_if.d_pc[1]); end
    checks++; if (fq_if.d_inst[0] !== 32'h0010_0000) begin errors++; $display("FAIL basic_inst0: got %h expected 00100000", fq_if.d_inst[0]); end
    checks++; if (fq_if.d_inst[1] !== 32'h0280_0421) begin errors++; $display("FAIL basic_inst1: got %h expected 02800421", fq_if.d_inst[1]); end
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", count_o); end
    fq_if.d_ready = 1'b1;
    tick();
    fq_if.d_ready = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL basic_drain: got %0d expected 0", count_o); end
    drive(1'b1, 2'b10, 32'h1C00_0004, 32'hFFFF_FFFF, 32'hDEAD_0001, 4'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++; if (fq_if.d_valid !== 2'b01) begin errors++; $display("FAIL mask10_valid: got %b expected 01", fq_if.d_valid); end
    checks++; if (fq_if.d_pc[0] !== 32'h1C00_0004) begin errors++; $display("FAIL mask10_pc0: got %h expected 1c000004", fq_if.d_pc[0]); end
    checks++; if (fq_if.d_inst[0] !== 32'hDEAD_0001) begin errors++; $display("FAIL mask10_inst0: got %h expected dead0001", fq_if.d_inst[0]); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b11, 32'h1C00_0100 + 32'(8 * k), 32'h0, 32'h0, 4'h0);
      tick();
    end
    drive(1'b1, 2'b11, 32'h1C00_0200, 32'h0, 32'h0, 4'h0);
    #1;
    checks++; if (count_o !== 4'd7) begin errors++; $display("FAIL full_count: got %0d expected 7", count_o); end
    checks++; if (fq_if.f_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", fq_if.f_ready); end
    tick();
    checks++; if (count_o !== 4'd7) begin errors++; $display("FAIL full_hold: got %0d expected 7", count_o); end
    fq_if.d_ready = 1'b1;
    tick();
    fq_if.d_ready = 1'b0;
    #1;
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL full_pop_count: got %0d expected 5", count_o); end
    checks++; if (fq_if.f_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", fq_if.f_ready); end
    checks++; if (fq_if.d_pc[0] !== 32'h1C00_0104) begin errors++; $display("FAIL full_pop_pc0: got %h expected 1c000104", fq_if.d_pc[0]); end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    checks++; if (count_o !== 4'd7) begin errors++; $display("FAIL full_refill: got %0d expected 7", count_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL full_flush: got %0d expected 0", count_o); end
  endtask

  task automatic test_steady();
    logic [31:0] e;
    drive(1'b1, 2'b11, 32'h1C00_1000, 32'h1C00_1000 ^ 32'h5A5A_0000, 32'h1C00_1004 ^ 32'h5A5A_0000, 4'h0);
    tick();
    fq_if.d_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      e = 32'h1C00_1000 + 32'(8 * j);
      drive(1'b1, 2'b11, e + 32'd8, (e + 32'd8) ^ 32'h5A5A_0000, (e + 32'd12) ^ 32'h5A5A_0000, 4'h0);
      #1;
      checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL steady_count[%0d]: got %0d expected 2", j, count_o); end
      checks++; if (fq_if.d_pc[0] !== e) begin errors++; $display("FAIL steady_pc0[%0d]: got %h expected %h", j, fq_if.d_pc[0], e); end
      checks++; if (fq_if.d_pc[1] !== e + 32'd4) begin errors++; $display("FAIL steady_pc1[%0d]: got %h expected %h", j, fq_if.d_pc[1], e + 32'd4); end
      checks++; if (fq_if.d_inst[1] !== ((e + 32'd4) ^ 32'h5A5A_0000)) begin errors++; $display("FAIL steady_inst1[%0d]: got %h", j, fq_if.d_inst[1]); end
      tick();
    end
    fq_if.d_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL steady_end_count: got %0d expected 2", count_o); end
    checks++; if (fq_if.d_pc[0] !== 32'h1C00_10A0) begin errors++; $display("FAIL steady_end_pc0: got %h expected 1c0010a0", fq_if.d_pc[0]); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_excp_flush();
    drive(1'b1, 2'b01, 32'h1C00_0200, 32'h1111_1111, 32'h2222_2222, 4'b0010);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++; if (fq_if.d_valid !== 2'b01) begin errors++; $display("FAIL excp_valid: got %b expected 01", fq_if.d_valid); end
    checks++; if (fq_if.d_excp[0] !== 4'b0010) begin errors++; $display("FAIL excp_flags: got %b expected 0010", fq_if.d_excp[0]); end
    checks++; if (fq_if.d_pc[0] !== 32'h1C00_0200) begin errors++; $display("FAIL excp_pc0: got %h expected 1c000200", fq_if.d_pc[0]); end
    checks++; if (fq_if.d_pkg[0] !== (32'h1C00_0200 ^ 32'hC0DE_0000)) begin errors++; $display("FAIL excp_pkg: got %h", fq_if.d_pkg[0]); end
    drive(1'b1, 2'b11, 32'h1C00_0208, 32'h0, 32'h0, 4'h0);
    tick();
    drive(1'b1, 2'b01, 32'h1C00_0210, 32'h0, 32'h0, 4'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    checks++; if (count_o !== 4'd4) begin errors++; $display("FAIL flush_pre_count: got %0d expected 4", count_o); end
    drive(1'b1, 2'b11, 32'h1C00_0218, 32'h0, 32'h0, 4'h0);
    flush_i = 1'b1;
    fq_if.d_ready = 1'b1;
    tick();
    flush_i = 1'b0;
    fq_if.d_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++; if (fq_if.d_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b expected 00", fq_if.d_valid); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL flush_stay: got %0d expected 0", count_o); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 2'b11, 32'h1C00_0300, 32'hAAAA_0000, 32'hBBBB_0000, 4'h0);
    fq_if.d_ready = 1'b1;
    #1;
`ifdef WIRED_FQ_BYPASS_EN
    checks++; if (fq_if.d_valid !== 2'b11) begin errors++; $display("FAIL byp_valid: got %b expected 11", fq_if.d_valid); end
    checks++; if (fq_if.d_pc[0] !== 32'h1C00_0300) begin errors++; $display("FAIL byp_pc0: got %h expected 1c000300", fq_if.d_pc[0]); end
    checks++; if (fq_if.d_pc[1] !== 32'h1C00_0304) begin errors++; $display("FAIL byp_pc1: got %h expected 1c000304", fq_if.d_pc[1]); end
    checks++; if (fq_if.d_inst[1] !== 32'hBBBB_0000) begin errors++; $display("FAIL byp_inst1: got %h expected bbbb0000", fq_if.d_inst[1]); end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    fq_if.d_ready = 1'b0;
    #1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL byp_count: got %0d expected 0", count_o); end
    checks++; if (fq_if.d_valid !== 2'b00) begin errors++; $display("FAIL byp_after: got %b expected 00", fq_if.d_valid); end
`else
    checks++; if (fq_if.d_valid !== 2'b00) begin errors++; $display("FAIL nobyp_valid: got %b expected 00", fq_if.d_valid); end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
    #1;
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL nobyp_count: got %0d expected 2", count_o); end
    checks++; if (fq_if.d_valid !== 2'b11) begin errors++; $display("FAIL nobyp_valid2: got %b expected 11", fq_if.d_valid); end
    checks++; if (fq_if.d_pc[1] !== 32'h1C00_0304) begin errors++; $display("FAIL nobyp_pc1: got %h expected 1c000304", fq_if.d_pc[1]); end
    tick();
    fq_if.d_ready = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL nobyp_drain: got %0d expected 0", count_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_steady();
    test_excp_flush();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
